// File: rtl/uart_pkt_tx.sv
// Packet framer for the UART transmitter: header, payload bytes LSB-first,
// then an 8-bit wrapping checksum, one byte per trmt/tx_done handshake.
module uart_pkt_tx #(
   parameter int         NUM_BYTES = 4,
   parameter logic [7:0] HEADER    = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   send,
   input  logic [8*NUM_BYTES-1:0] payload,
   output logic                   busy,
   output logic                   pkt_done,
   output logic                   trmt,
   output logic [7:0]             tx_data,
   input  logic                   tx_done
);

   typedef enum logic [1:0] {
      IDLE,
      STRB,
      CLR,
      WAIT
   } state_t;

   localparam logic [3:0] LAST = 4'(NUM_BYTES + 1);

   state_t                 state_q, state_d;
   logic [3:0]             idx_q, idx_d;
   logic [7:0]             acc_q, acc_d;
   logic [8*NUM_BYTES-1:0] pld_q, pld_d;
   logic [8*NUM_BYTES-1:0] pld_sh;
   logic [7:0]             pld_byte;
   logic                   busy_d, pkt_done_d, trmt_d;
   logic [7:0]             tx_data_d;
   logic                   accept, last;

   // The pkt_done cycle is already IDLE but must still reject send.
   assign accept   = send & ~pkt_done & (state_q == IDLE);
   assign last     = (idx_q == LAST);
   assign pld_sh   = pld_q >> {idx_q, 3'b000};
   assign pld_byte = pld_sh[7:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         acc_q    <= '0;
         pld_q    <= '0;
         busy     <= 1'b0;
         pkt_done <= 1'b0;
         trmt     <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         acc_q    <= acc_d;
         pld_q    <= pld_d;
         busy     <= busy_d;
         pkt_done <= pkt_done_d;
         trmt     <= trmt_d;
         tx_data  <= tx_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = STRB;
         STRB:    state_d = CLR;
         CLR:     state_d = WAIT;
         WAIT:    if (tx_done) state_d = last ? IDLE : STRB;
         default: state_d = IDLE;
      endcase
   end

   // Register inputs are computed one cycle ahead so every output is a flop.
   always_comb begin
      busy_d     = (state_d != IDLE);
      pkt_done_d = 1'b0;
      trmt_d     = 1'b0;
      tx_data_d  = tx_data_q_hold();
      idx_d      = idx_q;
      acc_d      = acc_q;
      pld_d      = pld_q;
      unique case (1'b1)
         accept: begin
            pld_d     = payload;
            idx_d     = 4'd0;
            acc_d     = HEADER;
            trmt_d    = 1'b1;
            tx_data_d = HEADER;
         end
         (state_q == STRB) && (idx_q != 4'd0) && !last: begin
            acc_d = acc_q + tx_data;
         end
         (state_q == WAIT) && tx_done && last: begin
            pkt_done_d = 1'b1;
         end
         (state_q == WAIT) && tx_done && !last: begin
            idx_d     = idx_q + 4'd1;
            trmt_d    = 1'b1;
            tx_data_d = (idx_q == LAST - 4'd1) ? acc_q : pld_byte;
         end
         default: ;
      endcase
   end

   function automatic logic [7:0] tx_data_q_hold();
      return tx_data;
   endfunction

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Randomized bench for uart_pkt_tx with a stub UART transmitter
// and a frame-level reference model.
module tb_uart_pkt_tx;

   localparam int         NB  = 4;
   localparam logic [7:0] HDR = 8'hA5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            send = 1'b0;
   logic [8*NB-1:0] payload = '0;
   logic            busy, pkt_done, trmt;
   logic [7:0]      tx_data;
   logic            tx_done;

   uart_pkt_tx #(.NUM_BYTES(NB), .HEADER(HDR)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .send     (send),
      .payload  (payload),
      .busy     (busy),
      .pkt_done (pkt_done),
      .trmt     (trmt),
      .tx_data  (tx_data),
      .tx_done  (tx_done)
   );

   always #5 clk = ~clk;

   int         cyc = 0;
   int         errs = 0;
   int         checks = 0;
   int         dly = -1;
   int         unstable = 0;
   int         bad_busy = 0;
   logic [7:0] got_q[$];
   int         trmt_cyc[$];
   int         pd_cyc[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Transmitter stub: done stays high, drops the cycle after trmt,
   // then returns high after dly extra cycles (random when dly < 0).
   initial begin
      int  cnt;
      bit  pend;
      cnt     = 0;
      pend    = 0;
      tx_done = 1'($urandom);
      forever begin
         @(posedge clk);
         #1;
         if (pend) begin
            tx_done = 1'b0;
            cnt     = (dly < 0) ? $urandom_range(0, 5) : dly;
            pend    = 0;
         end else if (cnt > 0) begin
            cnt--;
         end else begin
            tx_done = 1'b1;
         end
         if (trmt) pend = 1;
      end
   end

   initial begin
      logic [7:0] prev;
      prev = 8'h00;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (trmt) begin
               got_q.push_back(tx_data);
               trmt_cyc.push_back(cyc);
               if (!busy) bad_busy++;
            end else if (tx_data !== prev) begin
               unstable++;
            end
            if (pkt_done) begin
               pd_cyc.push_back(cyc);
               if (busy) bad_busy++;
            end
         end
         prev = tx_data;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_q();
      got_q.delete();
      trmt_cyc.delete();
      pd_cyc.delete();
   endtask

   task automatic start_pkt(input logic [8*NB-1:0] p, output int scyc);
      int n;
      n = 0;
      tick();
      while ((busy || pkt_done) && n < 500) begin
         tick();
         n++;
      end
      payload = p;
      send    = 1'b1;
      scyc    = cyc;
      tick();
      send    = 1'b0;
   endtask

   task automatic wait_pd(input int target, input bit noise);
      int n;
      n = 0;
      while (pd_cyc.size() < target && n < 3000) begin
         if (noise) begin
            send    = 1'($urandom_range(0, 1));
            payload = $urandom;
         end
         tick();
         n++;
      end
      send = 1'b0;
      chk("pd_timeout", 32'(pd_cyc.size() >= target), 1);
   endtask

   // Reference frame: header, payload bytes LSB-first, (header+sum) mod 256.
   task automatic check_frame(input string tag, input logic [8*NB-1:0] p,
                              input int base);
      int         sum;
      logic [7:0] b;
      chk({tag, "_len"}, 32'(got_q.size() >= base + NB + 2), 1);
      if (got_q.size() >= base + NB + 2) begin
         sum = HDR;
         chk({tag, "_hdr"}, got_q[base], HDR);
         for (int k = 0; k < NB; k++) begin
            b   = p[8*k +: 8];
            sum = (sum + b) % 256;
            chk($sformatf("%s_b%0d", tag, k), got_q[base+1+k], b);
         end
         chk({tag, "_cs"}, got_q[base+NB+1], sum);
      end
   endtask

   initial begin
      int          s;
      logic [31:0] p;
      int          n;

      repeat (3) tick();
      chk("rst_trmt", trmt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pkt_done", pkt_done, 0);
      chk("rst_tx_data", tx_data, 8'h00);
      rst_n = 1'b1;
      repeat (2) tick();

      clear_q();
      start_pkt(32'h04030201, s);
      wait_pd(1, 0);
      repeat (6) tick();
      check_frame("t1", 32'h04030201, 0);
      chk("t1_cs_const", got_q[5], 8'hAF);
      chk("t1_ntrmt", got_q.size(), 6);
      chk("t1_hdr_lat", trmt_cyc[0], s + 1);
      chk("t1_npd", pd_cyc.size(), 1);

      clear_q();
      start_pkt(32'hFFFFFFFF, s);
      wait_pd(1, 0);
      check_frame("t2", 32'hFFFFFFFF, 0);
      chk("t2_cs_const", got_q[5], 8'hA1);

      clear_q();
      p = $urandom;
      start_pkt(p, s);
      wait_pd(1, 1);
      repeat (10) tick();
      check_frame("t3", p, 0);
      chk("t3_ntrmt", got_q.size(), 6);
      chk("t3_npd", pd_cyc.size(), 1);

      clear_q();
      p = $urandom;
      tick();
      n = 0;
      while ((busy || pkt_done) && n < 500) begin
         tick();
         n++;
      end
      payload = p;
      send    = 1'b1;
      wait_pd(2, 0);
      repeat (10) tick();
      chk("t4_ntrmt", got_q.size(), 12);
      check_frame("t4a", p, 0);
      check_frame("t4b", p, 6);
      chk("t4_gap", trmt_cyc[6], pd_cyc[0] + 2);

      clear_q();
      dly = 6;
      p   = $urandom;
      start_pkt(p, s);
      n = 0;
      while (got_q.size() < 3 && n < 500) begin
         tick();
         n++;
      end
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      chk("t5_trmt", trmt, 0);
      chk("t5_busy", busy, 0);
      chk("t5_tx_data", tx_data, 8'h00);
      chk("t5_pkt_done", pkt_done, 0);
      clear_q();
      repeat (20) tick();
      rst_n = 1'b1;
      repeat (20) tick();
      chk("t5_quiet", got_q.size() + pd_cyc.size(), 0);
      dly = -1;
      p   = $urandom;
      start_pkt(p, s);
      wait_pd(1, 0);
      check_frame("t5", p, 0);

      clear_q();
      dly = 0;
      p   = $urandom;
      start_pkt(p, s);
      wait_pd(1, 0);
      check_frame("t6", p, 0);
      for (int k = 1; k < NB + 2; k++)
         chk($sformatf("t6_gap%0d", k), trmt_cyc[k] - trmt_cyc[k-1], 3);
      chk("t6_pd_lat", pd_cyc[0] - trmt_cyc[0], 3 * (NB + 1) + 3);

      dly = -1;
      for (int i = 0; i < 15; i++) begin
         clear_q();
         p = $urandom;
         start_pkt(p, s);
         wait_pd(1, 0);
         check_frame($sformatf("r%0d", i), p, 0);
         chk($sformatf("r%0d_lat", i), trmt_cyc[0], s + 1);
      end

      repeat (5) tick();
      chk("tx_data_stable", unstable, 0);
      chk("busy_flags", bad_busy, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
